// File: rtl/mem8x8_ctrl.sv
// mem8x8_ctrl: request/ack sequencer for the 8x8 bitcell array.
// Optional write readback and verify: define MEM8X8_CTRL_READBACK_EN.
module mem8x8_ctrl #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic [ROWS-1:0]  we,
  output logic [ROWS-1:0]  re,
  output logic [ROWS-1:0]  ren,
  output logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dinn,
  input  logic [WIDTH-1:0] dout
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    READ,
    CAPTURE,
    DONE
  } state_t;

  state_t           state_q;
  logic             wr_q;
  logic [AW-1:0]    addr_q;
  logic             rwait_q;
  logic [ROWS-1:0]  we_q;
  logic [ROWS-1:0]  re_q;
  logic [WIDTH-1:0] din_q;
  logic             ack_q;
  logic             busy_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;

  logic             oor;
  logic [ROWS-1:0]  row_oh;

  assign oor = 32'(addr_q) >= 32'(ROWS);

  // Out-of-range addresses still sequence but never strobe a row.
  always_comb begin
    row_oh = '0;
    if (!oor) row_oh[addr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      rwait_q <= 1'b0;
      we_q    <= '0;
      re_q    <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            wr_q    <= wr;
            addr_q  <= addr;
            rwait_q <= ~wr;
            busy_q  <= 1'b1;
            if (wr) din_q <= wdata;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // Reads spend an extra setup cycle letting the bus settle.
          if (rwait_q) begin
            rwait_q <= 1'b0;
          end else if (wr_q) begin
            we_q    <= row_oh;
            state_q <= WRITE;
          end else begin
            re_q    <= row_oh;
            state_q <= READ;
          end
        end
        WRITE: begin
          we_q    <= '0;
          state_q <= HOLD;
        end
        HOLD: begin
`ifdef MEM8X8_CTRL_READBACK_EN
          re_q    <= row_oh;
          state_q <= READ;
`else
          ack_q   <= 1'b1;
          err_q   <= oor;
          state_q <= DONE;
`endif
        end
        READ: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          re_q    <= '0;
          ack_q   <= 1'b1;
          state_q <= DONE;
          if (!wr_q) rdata_q <= oor ? '0 : dout;
`ifdef MEM8X8_CTRL_READBACK_EN
          err_q   <= oor | (wr_q & (dout != din_q));
`else
          err_q   <= oor;
`endif
        end
        DONE: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign we    = we_q;
  assign re    = re_q;
  assign ren   = ~re_q;
  assign din   = din_q;
  assign dinn  = ~din_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// tb_mem8x8_ctrl: array model, transaction-level reference and
// directed plus randomized stimulus for mem8x8_ctrl.
module tb_mem8x8_ctrl;

  localparam int R = 8;
`ifdef MEM8X8_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, req, wr;
  logic [2:0] addr;
  logic [7:0] wdata, rdata, din, dinn, dout;
  logic       ack, busy, err;
  logic [7:0] we, re, ren;

  always #5 clk = ~clk;

  mem8x8_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr),
    .addr(addr), .wdata(wdata), .ack(ack), .busy(busy),
    .rdata(rdata), .err(err), .we(we), .re(re), .ren(ren),
    .din(din), .dinn(dinn), .dout(dout)
  );

  // bitcell array with per-row stuck-at-0 masks
  logic [7:0] phys  [R];
  logic [7:0] stuck [R];

  always @(posedge clk)
    for (int i = 0; i < R; i++)
      if (we[i]) phys[i] <= din & ~stuck[i];

  always_comb begin
    dout = 8'h3C;
    for (int i = 0; i < R; i++)
      if (re[i]) dout = phys[i];
  end

  // reference: cycles since accept, latency per kind
  int         m_k, m_L;
  bit         m_live, m_wr;
  logic [2:0] m_a;
  logic [7:0] m_d, m_din, m_rdata;
  logic       m_err;
  logic [7:0] m_mem [R];

  always @(posedge clk) begin
    if (m_k == 2 && m_wr) m_mem[m_a] <= m_d & ~stuck[m_a];
    if (rst) begin
      m_k <= 0; m_din <= 8'h00; m_rdata <= 8'h00; m_live <= 1'b1;
    end else if (m_k == 0) begin
      if (req) begin
        m_wr <= wr; m_a <= addr; m_d <= wdata;
        if (wr) m_din <= wdata;
        m_L <= wr ? (RB ? 6 : 4) : 5;
        m_k <= 1;
      end
    end else if (m_k == m_L) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_L) begin
        m_err <= RB && m_wr && (m_mem[m_a] != m_d);
        if (!m_wr) m_rdata <= m_mem[m_a];
      end
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0] s_we, s_re, s_ren, s_din, s_dinn, s_rdata;
  logic       s_ack, s_busy, s_err;

  task automatic cmp();
    logic [7:0] e_we, e_re, e_ren, e_dinn;
    bit         e_ack;
    e_ack  = (m_k != 0) && (m_k == m_L);
    e_we   = (m_k == 2 && m_wr) ? (8'd1 << m_a) : 8'd0;
    e_re   = ((!m_wr && (m_k == 3 || m_k == 4)) ||
              (RB && m_wr && (m_k == 4 || m_k == 5))) ?
             (8'd1 << m_a) : 8'd0;
    e_ren  = ~e_re;
    e_dinn = ~m_din;
    chk("busy", 32'(s_busy), 32'(m_k != 0));
    chk("ack", 32'(s_ack), 32'(e_ack));
    chk("we", 32'(s_we), 32'(e_we));
    chk("re", 32'(s_re), 32'(e_re));
    chk("ren", 32'(s_ren), 32'(e_ren));
    chk("din", 32'(s_din), 32'(m_din));
    chk("dinn", 32'(s_dinn), 32'(e_dinn));
    chk("rdata", 32'(s_rdata), 32'(m_rdata));
    chk("we_and_re", 32'(s_we & s_re), 32'd0);
    if (e_ack) chk("err", 32'(s_err), 32'(m_err));
  endtask

  // sample the cycle at negedge, then step to just after the next edge
  task automatic tick();
    @(negedge clk);
    s_we = we; s_re = re; s_ren = ren; s_din = din; s_dinn = dinn;
    s_rdata = rdata; s_ack = ack; s_busy = busy; s_err = err;
    if (m_live) cmp();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] we_log [21];
  logic [7:0] re_log [21];
  logic [7:0] ren_log [21];
  logic [7:0] din_log [21];
  logic [7:0] dinn_log [21];

  task automatic txn(input bit w, input logic [2:0] a,
                     input logic [7:0] d, input bit scr,
                     output int lat, output logic e,
                     output logic [7:0] rd);
    req = 1'b1; wr = w; addr = a; wdata = d;
    tick();
    req = 1'b0;
    lat = -1; e = 1'b0; rd = 8'h00;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      if (scr && n <= 3) begin
        addr = 3'($urandom); wdata = 8'($urandom);
      end
      tick();
      we_log[n] = s_we; re_log[n] = s_re; ren_log[n] = s_ren;
      din_log[n] = s_din; dinn_log[n] = s_dinn;
      if (s_ack) begin lat = n; e = s_err; rd = s_rdata; end
    end
    if (lat < 0) begin
      nvec++; nerr++;
      $display("FAIL txn_timeout: no ack within 20 cycles");
    end
  endtask

  int         lat;
  logic       e;
  logic [7:0] rd;

  initial begin
    for (int i = 0; i < R; i++) stuck[i] = 8'h00;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 8'h00;
    tick();
    tick();
    chk("rst_ren", 32'(s_ren), 32'h0FF);
    chk("rst_dinn", 32'(s_dinn), 32'h0FF);
    chk("rst_din", 32'(s_din), 32'h0);
    chk("rst_rdata", 32'(s_rdata), 32'h0);
    chk("rst_busy", 32'(s_busy), 32'h0);
    chk("rst_ack", 32'(s_ack), 32'h0);
    rst = 1'b0;
    tick();

    txn(1'b1, 3'd3, 8'hA5, 1'b0, lat, e, rd);
    chk("wr3_lat", 32'(lat), RB ? 32'd6 : 32'd4);
    chk("wr3_we_c1", 32'(we_log[1]), 32'h00);
    chk("wr3_we_c2", 32'(we_log[2]), 32'h08);
    chk("wr3_we_c3", 32'(we_log[3]), 32'h00);
    chk("wr3_din", 32'(din_log[2]), 32'hA5);
    chk("wr3_dinn", 32'(dinn_log[2]), 32'h5A);
    chk("wr3_err", 32'(e), 32'h0);
    txn(1'b0, 3'd3, 8'h00, 1'b0, lat, e, rd);
    chk("rd3_lat", 32'(lat), 32'd5);
    chk("rd3_re_c2", 32'(re_log[2]), 32'h00);
    chk("rd3_re_c3", 32'(re_log[3]), 32'h08);
    chk("rd3_re_c4", 32'(re_log[4]), 32'h08);
    chk("rd3_ren_c3", 32'(ren_log[3]), 32'hF7);
    chk("rd3_data", 32'(rd), 32'hA5);
    chk("rd3_err", 32'(e), 32'h0);

    // back-to-back with req held high: 8 writes then 8 reads
    begin
      int j;
      j = 0;
      req = 1'b1; wr = 1'b1; addr = 3'd0; wdata = 8'h00;
      for (int c = 0; c < 200 && j < 16; c++) begin
        tick();
        if (s_ack) begin
          if (j >= 8) chk("b2b_rd", 32'(s_rdata), 32'((j - 8) * 17));
          j++;
          if (j < 16) begin
            wr = (j < 8); addr = 3'(j % 8); wdata = 8'((j % 8) * 17);
          end else begin
            req = 1'b0;
          end
        end
      end
      if (j < 16) begin
        nvec++; nerr++;
        $display("FAIL b2b_timeout: %0d of 16 acks", j);
      end
    end

    // inputs toggled while busy must not leak into the write
    txn(1'b1, 3'd5, 8'h5E, 1'b1, lat, e, rd);
    for (int i = 0; i < R; i++) begin
      txn(1'b0, 3'(i), 8'h00, 1'b0, lat, e, rd);
      chk($sformatf("row%0d_data", i), 32'(rd),
          (i == 5) ? 32'h5E : 32'(i * 17));
    end

    // reset during C3 of a read
    req = 1'b1; wr = 1'b0; addr = 3'd6;
    tick();
    req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_re_c3", 32'(s_re), 32'h40);
    rst = 1'b0;
    tick();
    chk("rstmid_re", 32'(s_re), 32'h00);
    chk("rstmid_rdata", 32'(s_rdata), 32'h00);
    chk("rstmid_busy", 32'(s_busy), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstmid_noack", 32'(s_ack), 32'h0);
    end
    txn(1'b0, 3'd6, 8'h00, 1'b0, lat, e, rd);
    chk("rstmid_next_rd", 32'(rd), 32'h66);
    chk("rstmid_next_lat", 32'(lat), 32'd5);

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      req   = ($urandom_range(0, 2) == 0);
      wr    = 1'($urandom);
      addr  = 3'($urandom);
      wdata = 8'($urandom);
      tick();
    end
    rst = 1'b0; req = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    // stuck-at-0 on bit 7 of row 2
    stuck[2] = 8'h80;
    txn(1'b1, 3'd2, 8'hFF, 1'b0, lat, e, rd);
    chk("stuck_wr_lat", 32'(lat), RB ? 32'd6 : 32'd4);
    chk("stuck_wr_err", 32'(e), RB ? 32'd1 : 32'd0);
    txn(1'b0, 3'd2, 8'h00, 1'b0, lat, e, rd);
    chk("stuck_rd_data", 32'(rd), 32'h7F);
    stuck[2] = 8'h00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem8x8_ctrl.md
# mem8x8_ctrl

Sequencing controller for the 8x8 bitcell memory array. It accepts single-word read/write requests over a req/ack handshake and decodes the address into one-hot row strobes. It drives the differential write data and the complementary read-enable pairs, then captures the shared tri-state read bus into a register. It sits between the user logic and the array, and guarantees that `we` and `re` are never asserted together and that at most one row drives the bus at any time.

## Interface

Parameters:

- `WIDTH`, 8, bits per word (columns)
- `ROWS`, 8, number of words (rows)
- `AW`, 3, address width; `2**AW >= ROWS`

Ports:

- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  1  request; sampled only in IDLE
- `wr`  in  1  1 = write, 0 = read; latched on accept
- `addr`  in  AW  word address; latched on accept
- `wdata`  in  WIDTH  write data; latched on accept
- `ack`  out  1  one-cycle completion pulse
- `busy`  out  1  high from the accept cycle until `ack`, inclusive
- `rdata`  out  WIDTH  registered read data; updated only on a read `ack`
- `err`  out  1  valid with `ack`: address out of range, or readback mismatch
- `we`  out  ROWS  one-hot row write enable to the array
- `re`  out  ROWS  one-hot row read enable
- `ren`  out  ROWS  always equals `~re`
- `din`  out  WIDTH  array write data (`inp`)
- `dinn`  out  WIDTH  always equals `~din` (`inpn`)
- `dout`  in  WIDTH  shared tri-state read bus from the array (`outp`)

## Operation

- FSM states: IDLE, SETUP, WRITE, HOLD, READ, CAPTURE, DONE.
- IDLE:
  - If `req`=1, latch `wr`, `addr` and `wdata`, set `busy`=1, and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - Drive `din` from the latched data on a write; hold `din` on a read.
  - All strobes stay low.
  - Go to WRITE if the operation is a write, otherwise go to READ.
- WRITE: `we[addr]`=1 for exactly one cycle; go to HOLD.
- HOLD: `we`=0 while `din` is held for one cycle. Go to DONE, or to READ when readback is enabled (see Configuration).
- READ: `re[addr]`=1 and `ren[addr]`=0; go to CAPTURE.
- CAPTURE:
  - `re` stays asserted.
  - `dout` is sampled at the end of this cycle into a capture register.
  - Go to DONE.
- DONE:
  - `ack`=1 and all strobes are 0.
  - `rdata` is loaded from the capture register on reads only.
  - `busy` drops next cycle; return to IDLE.
- Out-of-range address (`addr >= ROWS`):
  - The full state sequence still runs, but no `we` or `re` bit is ever asserted.
  - `ack` arrives with `err`=1; `rdata`=0 on a read.
- `req` and the inputs are ignored while `busy`=1. Changing `addr` or `wdata` mid-transaction has no effect.
- `req` held high across `ack` starts a new transaction on the first IDLE cycle after DONE. There is always at least one IDLE cycle between transactions.
- Invariants, checked every cycle:
  - `we & re` == 0
  - `$onehot0(we)` and `$onehot0(re)`
  - `ren == ~re` and `dinn == ~din`

## Timing

- Reset values: FSM=IDLE, `we`=0, `re`=0, `ren`=all ones, `din`=0, `dinn`=all ones, `ack`=0, `busy`=0, `rdata`=0, `err`=0.
- All outputs are registered.
- Latency is counted from the accept edge (C0, `req`=1 seen in IDLE):
  - Write: `we` is high in cycle C2 and `ack` is high in cycle C4.
  - Read: `re` is high in cycles C3–C4, data is sampled at the end of C4, `ack` is high in C5, and `rdata` is valid from C5.
- Maximum throughput is one transaction per 6 cycles for a read and per 5 cycles for a write.
- `rst` mid-transaction:
  - All strobes drop at the next edge and `ack` is not issued.
  - `rdata` returns to 0 and the FSM goes to IDLE.

## Configuration

- Macro: `MEM8X8_CTRL_READBACK_EN`.
- Defined:
  - A write continues HOLD → READ → CAPTURE → DONE, so write `ack` arrives in C6.
  - The captured word is compared with the latched `wdata`; a mismatch sets `err`=1 with `ack`.
  - `rdata` is not updated by writes.
- Undefined:
  - Write goes HOLD → DONE.
  - `err` flags only out-of-range addresses.

## Test plan

- Reset: hold `rst` for 2 cycles → every output at its listed reset value; `ren`=8'hFF and `dinn`=8'hFF.
- Write `addr`=3, `wdata`=8'hA5, then read `addr`=3:
  - Write: `we`=8'h08 for exactly one cycle (C2), `din`=8'hA5, `dinn`=8'h5A.
  - Read: `re`=8'h08 and `ren`=8'hF7 in C3–C4, `rdata`=8'hA5 at `ack`, `err`=0.
- Back-to-back: `req` held high with writes to all 8 rows (data = row index ×17), then reads of all 8 → each `ack` is one cycle, with at least one IDLE cycle between transactions; read data matches; the invariant assertions never fire.
- Input change while busy: toggle `addr` and `wdata` during cycles C1–C3 of a write to row 5 → only row 5 is written, with the originally latched data.
- `rst` asserted in C3 of a read → no `ack`, `re`=0 on the next edge, `rdata`=0, FSM in IDLE; the next read completes normally.
- Readback (macro defined): the bench model forces a stuck-at-0 on bit 7 of row 2, then a write of 8'hFF to row 2 → `ack` in C6 with `err`=1. Without the macro, the same write gives `ack` in C4 with `err`=0.
